// File: rtl/pacman_move_ctrl.sv
// rtl/pacman_move_ctrl.sv - Pac-Man move controller: buttons to wall-checked grid moves for the map writer
module pacman_move_ctrl #(
  parameter int COLS        = 40,
  parameter int ROWS        = 30,
  parameter int MOVE_PERIOD = 5000000,
  parameter int START_X     = 20,
  parameter int START_Y     = 22
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              done,
  input  logic [4*COLS-1:0] rddata,
  output logic [4:0]        rdaddr,
  output logic [5:0]        curr_pacman_x,
  output logic [4:0]        curr_pacman_y,
  output logic [5:0]        next_pacman_x,
  output logic [4:0]        next_pacman_y,
  output logic              ready,
  output logic [1:0]        heading
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [5:0] X_MAX   = 6'(COLS - 1);
  localparam logic [4:0] Y_MAX   = 5'(ROWS - 1);
  localparam logic [5:0] X_START = 6'(START_X);
  localparam logic [4:0] Y_START = 5'(START_Y);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] CELL_WALL = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD1,
    S_RD2,
    S_CHECK,
    S_PRESENT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_pending_q, tick_pending_d;
  logic             req_valid_q, req_valid_d;
  logic [1:0]       req_dir_q, req_dir_d;
  logic [1:0]       heading_q, heading_d;
  logic [1:0]       cand_dir_q, cand_dir_d;
  logic             cand_is_req_q, cand_is_req_d;
  logic [5:0]       tgt_x_q, tgt_x_d;
  logic [4:0]       tgt_y_q, tgt_y_d;
  logic [4:0]       rdaddr_q, rdaddr_d;
  logic [5:0]       curr_x_q, curr_x_d, next_x_q, next_x_d;
  logic [4:0]       curr_y_q, curr_y_d, next_y_q, next_y_d;
  logic             ready_q, ready_d;

  logic       tick_wrap;
  logic       btn_any;
  logic [1:0] btn_dir;
  logic       req_clear;
  logic [1:0] sel_dir;
  logic [5:0] calc_x;
  logic [4:0] calc_y;
  logic [3:0] tgt_cell;

  assign tick_wrap = (tick_cnt_q == CNT_LAST);
  assign tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;

  // Button priority encoder: up > down > left > right.
  always_comb begin
    btn_any = up | down | left | right;
    btn_dir = DIR_RIGHT;
    if (up)        btn_dir = DIR_UP;
    else if (down) btn_dir = DIR_DOWN;
    else if (left) btn_dir = DIR_LEFT;
  end

  // Request latch: any held button reloads it, even on the cycle it is consumed.
  always_comb begin
    req_valid_d = req_valid_q;
    req_dir_d   = req_dir_q;
    if (btn_any) begin
      req_valid_d = 1'b1;
      req_dir_d   = btn_dir;
    end else if (req_clear) begin
      req_valid_d = 1'b0;
    end
  end

  // First attempt uses the request if any; the retry from CHECK always uses the heading.
  assign sel_dir = (state_q == S_CALC && req_valid_q) ? req_dir_q : heading_q;

  // Target cell one step from curr in sel_dir, with tunnel wrap on every edge.
  always_comb begin
    calc_x = curr_x_q;
    calc_y = curr_y_q;
    case (sel_dir)
      DIR_UP:   calc_y = (curr_y_q == 5'd0)  ? Y_MAX : curr_y_q - 5'd1;
      DIR_DOWN: calc_y = (curr_y_q == Y_MAX) ? 5'd0  : curr_y_q + 5'd1;
      DIR_LEFT: calc_x = (curr_x_q == 6'd0)  ? X_MAX : curr_x_q - 6'd1;
      default:  calc_x = (curr_x_q == X_MAX) ? 6'd0  : curr_x_q + 6'd1;
    endcase
  end

  // Pick the 4-bit cell at the target column; column 0 sits in the top nibble.
  always_comb begin
    tgt_cell = 4'd0;
    for (int i = 0; i < COLS; i++) begin
      if (tgt_x_q == 6'(i)) tgt_cell = rddata[4*(COLS-1-i) +: 4];
    end
  end

  // Move FSM: next state plus all datapath register updates.
  always_comb begin
    state_d        = state_q;
    tick_pending_d = tick_pending_q | tick_wrap;
    req_clear      = 1'b0;
    heading_d      = heading_q;
    cand_dir_d     = cand_dir_q;
    cand_is_req_d  = cand_is_req_q;
    tgt_x_d        = tgt_x_q;
    tgt_y_d        = tgt_y_q;
    rdaddr_d       = rdaddr_q;
    curr_x_d       = curr_x_q;
    curr_y_d       = curr_y_q;
    next_x_d       = next_x_q;
    next_y_d       = next_y_q;
    ready_d        = ready_q;
    case (state_q)
      S_IDLE: begin
        if (tick_pending_q) begin
          tick_pending_d = tick_wrap;
          state_d        = S_CALC;
        end
      end
      S_CALC: begin
        cand_dir_d    = sel_dir;
        cand_is_req_d = req_valid_q;
        tgt_x_d       = calc_x;
        tgt_y_d       = calc_y;
        rdaddr_d      = calc_y;
        state_d       = S_RD1;
      end
      S_RD1: state_d = S_RD2;
      S_RD2: state_d = S_CHECK;
      S_CHECK: begin
        if (tgt_cell != CELL_WALL) begin
          next_x_d  = tgt_x_q;
          next_y_d  = tgt_y_q;
          heading_d = cand_dir_q;
          req_clear = 1'b1;
          ready_d   = 1'b1;
          state_d   = S_PRESENT;
        end else if (cand_is_req_q && cand_dir_q != heading_q) begin
          req_clear     = 1'b1;
          cand_dir_d    = heading_q;
          cand_is_req_d = 1'b0;
          tgt_x_d       = calc_x;
          tgt_y_d       = calc_y;
          rdaddr_d      = calc_y;
          state_d       = S_RD1;
        end else begin
          req_clear = cand_is_req_q;
          state_d   = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (done) begin
          curr_x_d = next_x_q;
          curr_y_d = next_y_q;
          ready_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any move in flight.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      req_valid_q    <= 1'b0;
      req_dir_q      <= DIR_UP;
      heading_q      <= DIR_RIGHT;
      cand_dir_q     <= DIR_RIGHT;
      cand_is_req_q  <= 1'b0;
      tgt_x_q        <= X_START;
      tgt_y_q        <= Y_START;
      rdaddr_q       <= Y_START;
      curr_x_q       <= X_START;
      curr_y_q       <= Y_START;
      next_x_q       <= X_START;
      next_y_q       <= Y_START;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      req_valid_q    <= req_valid_d;
      req_dir_q      <= req_dir_d;
      heading_q      <= heading_d;
      cand_dir_q     <= cand_dir_d;
      cand_is_req_q  <= cand_is_req_d;
      tgt_x_q        <= tgt_x_d;
      tgt_y_q        <= tgt_y_d;
      rdaddr_q       <= rdaddr_d;
      curr_x_q       <= curr_x_d;
      curr_y_q       <= curr_y_d;
      next_x_q       <= next_x_d;
      next_y_q       <= next_y_d;
      ready_q        <= ready_d;
    end
  end

  assign rdaddr        = rdaddr_q;
  assign curr_pacman_x = curr_x_q;
  assign curr_pacman_y = curr_y_q;
  assign next_pacman_x = next_x_q;
  assign next_pacman_y = next_y_q;
  assign ready         = ready_q;
  assign heading       = heading_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// tb/tb_pacman_move_ctrl.sv - directed self-checking bench for pacman_move_ctrl
`timescale 1ns/1ps
module tb_pacman_move_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up, down, left, right, done;
  logic [159:0] rddata;
  logic [4:0]   rdaddr;
  logic [5:0]   curr_pacman_x, next_pacman_x;
  logic [4:0]   curr_pacman_y, next_pacman_y;
  logic         ready;
  logic [1:0]   heading;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pacman_move_ctrl #(
    .COLS(40), .ROWS(30), .MOVE_PERIOD(8), .START_X(20), .START_Y(22)
  ) dut (
    .CLOCK_50(clk), .reset(rst_n),
    .up(up), .down(down), .left(left), .right(right), .done(done),
    .rddata(rddata), .rdaddr(rdaddr),
    .curr_pacman_x(curr_pacman_x), .curr_pacman_y(curr_pacman_y),
    .next_pacman_x(next_pacman_x), .next_pacman_y(next_pacman_y),
    .ready(ready), .heading(heading)
  );

  // Map RAM model: two-cycle read latency.
  logic [159:0] map_mem [32];
  logic [159:0] rd_stage;
  always @(posedge clk) begin
    rd_stage <= map_mem[rdaddr];
    rddata   <= rd_stage;
  end

  // Log of distinct read addresses while enabled.
  logic     mon_en = 1'b0;
  logic [4:0] last_rd;
  int       rd_log[$];
  always @(negedge clk) begin
    if (mon_en && rdaddr != last_rd) begin
      rd_log.push_back(int'(rdaddr));
      last_rd = rdaddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cell(input int x, input int y, input logic [3:0] v);
    map_mem[y][4*(39-x) +: 4] = v;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ready), 1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic press(input logic [1:0] d);
    up = (d == 2'd0); down = (d == 2'd1); left = (d == 2'd2); right = (d == 2'd3);
    @(negedge clk);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int cx, input int cy, input int nx, input int ny);
    chk({tag, "_curr_x"}, 32'(curr_pacman_x), cx);
    chk({tag, "_curr_y"}, 32'(curr_pacman_y), cy);
    chk({tag, "_next_x"}, 32'(next_pacman_x), nx);
    chk({tag, "_next_y"}, 32'(next_pacman_y), ny);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; done = 1'b0;
    for (int i = 0; i < 32; i++) map_mem[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_pos("rst", 20, 22, 20, 22);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_heading", 32'(heading), 3);
    chk("rst_rdaddr", 32'(rdaddr), 22);
    rst_n = 1'b1;

    // Default move right on open row, then commit.
    wait_ready("t1_ready");
    chk_pos("t1", 20, 22, 21, 22);
    chk("t1_heading", 32'(heading), 3);
    pulse_done();
    chk("t1_done_ready", 32'(ready), 0);
    chk("t1_done_curr_x", 32'(curr_pacman_x), 21);

    // Up into a wall falls back to heading: two reads, row 21 then 22.
    set_cell(21, 21, 4'd1);
    last_rd = rdaddr;
    mon_en  = 1'b1;
    press(2'd0);
    wait_ready("t2_ready");
    mon_en = 1'b0;
    chk("t2_nreads", 32'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("t2_read0", 32'(rd_log[0]), 21);
      chk("t2_read1", 32'(rd_log[1]), 22);
    end
    chk_pos("t2", 21, 22, 22, 22);
    chk("t2_heading", 32'(heading), 3);
    pulse_done();

    // Right-edge tunnel.
    for (int i = 0; i < 20; i++) begin
      wait_ready("t3_step");
      if (curr_pacman_x == 6'd39) break;
      pulse_done();
    end
    chk_pos("t3_tunnel_x", 39, 22, 0, 22);
    pulse_done();

    // Top-edge tunnel going up from (0,0).
    press(2'd0);
    for (int i = 0; i < 30; i++) begin
      wait_ready("t3_up_step");
      if (curr_pacman_y == 5'd0) break;
      pulse_done();
    end
    chk_pos("t3_tunnel_y", 0, 0, 0, 29);
    chk("t3_heading_up", 32'(heading), 0);
    pulse_done();

    // Both sides walled, request left: stays blocked, request dropped.
    press(2'd3);
    wait_ready("t4_setup");
    chk_pos("t4_setup", 0, 29, 1, 29);
    pulse_done();
    set_cell(0, 29, 4'd1);
    set_cell(2, 29, 4'd1);
    press(2'd2);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) bad++;
    end
    chk("t4_ready_seen", 32'(bad), 0);
    chk_pos("t4", 1, 29, 1, 29);
    chk("t4_heading", 32'(heading), 3);
    set_cell(0, 29, 4'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) bad++;
    end
    chk("t4_req_cleared", 32'(bad), 0);

    // Long hold in PRESENT, then immediate move from the collapsed pending tick.
    set_cell(2, 29, 4'd0);
    wait_ready("t5_ready");
    chk_pos("t5", 1, 29, 2, 29);
    bad = 0;
    repeat (160) begin
      @(negedge clk);
      if (!ready || next_pacman_x != 6'd2 || next_pacman_y != 5'd29 ||
          curr_pacman_x != 6'd1 || curr_pacman_y != 5'd29 || rdaddr != 5'd29) bad++;
    end
    chk("t5_hold_stable", 32'(bad), 0);
    pulse_done();
    chk("t5_done_ready", 32'(ready), 0);
    chk("t5_done_curr_x", 32'(curr_pacman_x), 2);
    repeat (4) @(negedge clk);
    chk("t5_early_ready", 32'(ready), 0);
    @(negedge clk);
    chk("t5_latency_ready", 32'(ready), 1);
    chk_pos("t5_next", 2, 29, 3, 29);

    // Asynchronous reset during RD2.
    repeat (20) @(negedge clk);
    pulse_done();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_pos("t6_async", 20, 22, 20, 22);
    chk("t6_ready", 32'(ready), 0);
    chk("t6_heading", 32'(heading), 3);
    chk("t6_rdaddr", 32'(rdaddr), 22);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("t6_after_ready");
    chk_pos("t6_after", 20, 22, 21, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
